// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mdu_pkg;

    // Operation select on the op port. Bit 1 selects divide, bit 0 selects unsigned.
    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } mdu_state_e;

    // One iteration per operand bit.
    localparam int MDU_ITERS = 32;

endpackage

// File: rtl/mdu_hilo_if.sv
// Request/result bundle between the issue stage and the multiply/divide unit.
// Latency: n/a (wiring only).
// Backpressure: requester must watch busy; start is dropped while busy.
// master: start, op, rs_data, rt_data, hi_we, lo_we, wdata out; busy, done, div_zero, hi, lo in.
// slave : the reverse.
interface mdu_hilo_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_data, rt_data, hi_we, lo_we, wdata,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, hi_we, lo_we, wdata,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mdu_step.sv
// One combinational iteration of shift-add multiply or restoring divide.
// Latency: combinational.
// Backpressure: none; the caller decides when to register acc_nxt.
// Ports: acc (2*WIDTH+1 accumulator), opnd (multiplicand or divisor), is_div (mode),
//        acc_nxt (next accumulator, quotient LSB left zero), q_bit (new quotient bit).
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0]  acc,
    input  logic [WIDTH-1:0]  opnd,
    input  logic              is_div,
    output logic [2*WIDTH:0]  acc_nxt,
    output logic              q_bit
);

    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_trial;

    // Multiply layout: acc = {partial_upper[WIDTH:0], multiplier/low product[WIDTH-1:0]}.
    // Divide layout:   acc = {unused, remainder[WIDTH-1:0], dividend/quotient[WIDTH-1:0]}.
    always_comb begin
        mul_sum   = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd};
        q_bit     = 1'b0;
        acc_nxt   = '0;
        if (is_div) begin
            // Remainder stays below the divisor, so the trial's top bit is a clean borrow.
            q_bit   = ~div_trial[WIDTH];
            acc_nxt = {(q_bit ? div_trial : div_shift), acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_nxt = {1'b0, mul_sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Latency: 33 edges from accept to done (1 edge for divide by zero).
// Backpressure: busy high while an op runs; start and MTHI/MTLO are ignored then.
// Ports: clk, rst_n (sync, active low), bus (mdu_hilo_if.slave: request in, HI/LO/status out).
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITERS = MDU_ITERS   // must equal WIDTH
) (
    input logic        clk,
    input logic        rst_n,
    mdu_hilo_if.slave  bus
);

    localparam int CW = $clog2(ITERS);

    mdu_state_e       state;
    logic             is_div_r;
    logic             neg_res;     // result (product or quotient) needs negating
    logic             neg_rem;     // remainder takes the dividend's sign
    logic             dz_r;        // current op is a divide by zero
    logic [WIDTH-1:0] opnd;
    logic [2*WIDTH:0] acc;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             busy_r;
    logic             done_r;
    logic             dz_flag;

    logic             in_signed;
    logic             rs_neg;
    logic             rt_neg;
    logic [WIDTH-1:0] rs_mag;
    logic [WIDTH-1:0] rt_mag;
    logic [2*WIDTH:0] step_acc;
    logic             step_q;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign in_signed = ~bus.op[0];
    assign rs_neg    = in_signed & bus.rs_data[WIDTH-1];
    assign rt_neg    = in_signed & bus.rt_data[WIDTH-1];
    assign rs_mag    = rs_neg ? -bus.rs_data : bus.rs_data;
    assign rt_mag    = rt_neg ? -bus.rt_data : bus.rt_data;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .acc     (acc),
        .opnd    (opnd),
        .is_div  (is_div_r),
        .acc_nxt (step_acc),
        .q_bit   (step_q)
    );

    // Sign fix-up on the magnitude result. 0x8000_0000 / -1 wraps naturally to 0x8000_0000.
    assign prod_fix = neg_res ? -acc[2*WIDTH-1:0]     : acc[2*WIDTH-1:0];
    assign quo_fix  = neg_res ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0];
    assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            is_div_r <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            dz_r     <= 1'b0;
            opnd     <= '0;
            acc      <= '0;
            count    <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dz_flag  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        // start has priority; a concurrent MTHI/MTLO is dropped
                        is_div_r <= bus.op[1];
                        neg_res  <= rs_neg ^ rt_neg;
                        neg_rem  <= rs_neg;
                        dz_flag  <= 1'b0;
                        count    <= '0;
                        busy_r   <= 1'b1;
                        if (bus.op[1] && (bus.rt_data == '0)) begin
                            // keep the raw dividend: it becomes HI unmodified
                            dz_r  <= 1'b1;
                            opnd  <= '0;
                            acc   <= {{(WIDTH+1){1'b0}}, bus.rs_data};
                            state <= S_FIX;
                        end else begin
                            dz_r  <= 1'b0;
                            opnd  <= bus.op[1] ? rt_mag : rs_mag;
                            acc   <= {{(WIDTH+1){1'b0}}, (bus.op[1] ? rs_mag : rt_mag)};
                            state <= S_RUN;
                        end
                    end else begin
                        if (bus.hi_we) hi_r <= bus.wdata;
                        if (bus.lo_we) lo_r <= bus.wdata;
                    end
                end
                S_RUN: begin
                    acc <= step_acc | {{(2*WIDTH){1'b0}}, step_q};
                    if (count == CW'(ITERS-1)) begin
                        state <= S_FIX;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                S_FIX: begin
                    if (dz_r) begin
                        lo_r    <= '1;
                        hi_r    <= acc[WIDTH-1:0];
                        dz_flag <= 1'b1;
                    end else if (is_div_r) begin
                        lo_r <= quo_fix;
                        hi_r <= rem_fix;
                    end else begin
                        {hi_r, lo_r} <= prod_fix;
                    end
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.div_zero = dz_flag;
    assign bus.hi       = hi_r;
    assign bus.lo       = lo_r;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo with a cycle-level arithmetic model and per-cycle compare.
// Latency: n/a.
// Backpressure: n/a.
module tb_mdu_hilo;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mdu_hilo_if #(.WIDTH(32)) bus ();

    mdu_hilo #(.WIDTH(32), .ITERS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model state: what HI/LO/status must be, from the arithmetic rules alone.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    bit          m_busy, m_done, m_dz, p_dz;
    int          remain;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compute the architectural result of an accepted op.
    task automatic model_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] rhi, output logic [31:0] rlo, output bit rdz,
                                output int cycles);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        rdz = 1'b0;
        cycles = 33;
        case (o)
            MDU_MULT:  begin p = sa * sb; rhi = p[63:32]; rlo = p[31:0]; end
            MDU_MULTU: begin p = {32'b0, a} * {32'b0, b}; rhi = p[63:32]; rlo = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    rhi = a; rlo = 32'hFFFF_FFFF; rdz = 1'b1; cycles = 1;
                end else if (o == MDU_DIV) begin
                    q = sa / sb; r = sa % sb;
                    rlo = q[31:0]; rhi = r[31:0];
                end else begin
                    rlo = a / b; rhi = a % b;
                end
            end
        endcase
    endtask

    initial begin
        m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0;
        m_busy = 0; m_done = 0; m_dz = 0; p_dz = 0; remain = 0;
        forever begin
            @(posedge clk);
            m_done = 1'b0;
            if (!rst_n) begin
                m_hi = '0; m_lo = '0; m_busy = 0; m_dz = 0; remain = 0;
            end else if (!m_busy) begin
                if (bus.start) begin
                    model_result(bus.op, bus.rs_data, bus.rt_data, p_hi, p_lo, p_dz, remain);
                    m_busy = 1'b1;
                    m_dz   = 1'b0;
                end else begin
                    if (bus.hi_we) m_hi = bus.wdata;
                    if (bus.lo_we) m_lo = bus.wdata;
                end
            end else begin
                remain--;
                if (remain == 0) begin
                    m_busy = 1'b0; m_done = 1'b1;
                    m_hi = p_hi; m_lo = p_lo; m_dz = p_dz;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("busy",     64'(bus.busy),     64'(m_busy));
                chk("done",     64'(bus.done),     64'(m_done));
                chk("div_zero", 64'(bus.div_zero), 64'(m_dz));
                chk("hi",       64'(bus.hi),       64'(m_hi));
                chk("lo",       64'(bus.lo),       64'(m_lo));
            end
        end
    end

    // Literal expectations checked against both the DUT and the model.
    task automatic check_res(input string name, input logic [31:0] ehi, input logic [31:0] elo);
        chk({name, "_hi"},     64'(bus.hi), 64'(ehi));
        chk({name, "_lo"},     64'(bus.lo), 64'(elo));
        chk({name, "_mdl_hi"}, 64'(m_hi),   64'(ehi));
        chk({name, "_mdl_lo"}, 64'(m_lo),   64'(elo));
    endtask

    // Present a request for one edge (E0); leaves inputs idle at E0+1.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1; bus.op = o; bus.rs_data = a; bus.rt_data = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    endtask

    // Count busy cycles and done pulses over a fixed window longer than any op.
    task automatic observe(output int busy_cyc, output int done_cnt);
        busy_cyc = 0; done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.busy) busy_cyc++;
            if (bus.done) done_cnt++;
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_busy,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int bc, dc;
        launch(o, a, b);
        observe(bc, dc);
        chk({name, "_busycyc"}, 64'(bc), 64'(exp_busy));
        chk({name, "_donecnt"}, 64'(dc), 64'd1);
        check_res(name, ehi, elo);
    endtask

    initial begin
        int bc, dc;
        rst_n = 1'b0;
        bus.start = 0; bus.op = '0; bus.rs_data = '0; bus.rt_data = '0;
        bus.hi_we = 0; bus.lo_we = 0; bus.wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_dz",   64'(bus.div_zero), 64'd0);
        check_res("rst", 32'h0, 32'h0);

        run_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg",  MDU_MULT,  32'hFFFF_FFFD, 32'd7,         33, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("div_neg",   MDU_DIV,   32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_negdv", MDU_DIV,   32'd100,       32'hFFFF_FFF9, 33, 32'd2,         32'hFFFF_FFF2);
        run_op("divu_big",  MDU_DIVU,  32'hFFFF_FFFF, 32'd3,         33, 32'd0,         32'h5555_5555);

        run_op("divu_zero", MDU_DIVU,  32'd100, 32'd0, 1, 32'd100, 32'hFFFF_FFFF);
        chk("divu_zero_flag", 64'(bus.div_zero), 64'd1);
        run_op("multu_clr", MDU_MULTU, 32'd2, 32'd3, 33, 32'd0, 32'd6);
        chk("multu_clr_flag", 64'(bus.div_zero), 64'd0);
        run_op("div_zero_raw", MDU_DIV, 32'hFFFF_FFF9, 32'd0, 1, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

        run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000);
        chk("div_ovf_flag", 64'(bus.div_zero), 64'd0);

        // start together with MT writes in IDLE: start wins
        bus.hi_we = 1'b1; bus.wdata = 32'hDEAD_BEEF;
        run_op("start_wins", MDU_MULTU, 32'd2, 32'd2, 33, 32'd0, 32'd4);

        // requests while busy are ignored
        launch(MDU_MULTU, 32'd7, 32'd6);
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.op = MDU_DIVU; bus.rs_data = 32'd1; bus.rt_data = 32'd0;
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h0000_1234;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        observe(bc, dc);
        chk("busy_ign_donecnt", 64'(dc), 64'd1);
        check_res("busy_ign", 32'd0, 32'd42);
        chk("busy_ign_dz", 64'(bus.div_zero), 64'd0);

        // MTHI in IDLE
        bus.hi_we = 1'b1; bus.wdata = 32'h0000_1234;
        @(posedge clk);
        #1;
        bus.hi_we = 1'b0;
        @(negedge clk);
        check_res("mthi", 32'h0000_1234, 32'd42);

        // MTLO alone
        bus.lo_we = 1'b1; bus.wdata = 32'hCAFE_0001;
        @(posedge clk);
        #1;
        bus.lo_we = 1'b0;
        @(negedge clk);
        check_res("mtlo", 32'h0000_1234, 32'hCAFE_0001);

        // reset in the middle of an op: sampled low at E10
        launch(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        observe(bc, dc);
        chk("midrst_busycyc", 64'(bc), 64'd0);
        chk("midrst_donecnt", 64'(dc), 64'd0);
        check_res("midrst", 32'h0, 32'h0);

        run_op("multu_5x5", MDU_MULTU, 32'd5, 32'd5, 33, 32'd0, 32'd25);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
